// File: rtl/mem_arb_pkg.sv
// Shared encodings for the memory bus arbiter: FSM states, grant owner and bus size codes.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAddr = 2'd1,
        StData = 2'd2
    } arb_state_e;

    typedef enum logic {
        GrantInst = 1'b0,
        GrantData = 1'b1
    } arb_grant_e;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/mem_arb_perf.sv
// Stall and discarded-fetch cycle counters; only built when MEM_BUS_ARBITER_PERF_EN is defined.
module mem_arb_perf (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_if_i,
    input  logic        stall_mem_i,
    input  logic        discard_i,
    output logic [31:0] perf_if_stall_o,
    output logic [31:0] perf_mem_stall_o,
    output logic [31:0] perf_discard_o
);

    logic [31:0] if_stall_q, mem_stall_q, discard_q;

    // Counters wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_stall_q  <= '0;
            mem_stall_q <= '0;
            discard_q   <= '0;
        end else begin
            if (stall_if_i)  if_stall_q  <= if_stall_q + 32'd1;
            if (stall_mem_i) mem_stall_q <= mem_stall_q + 32'd1;
            if (discard_i)   discard_q   <= discard_q + 32'd1;
        end
    end

    assign perf_if_stall_o  = if_stall_q;
    assign perf_mem_stall_o = mem_stall_q;
    assign perf_discard_o   = discard_q;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates one SRAM-like bus between fetch (IF) and load/store (MEM); MEM has priority.
// Defining MEM_BUS_ARBITER_PERF_EN adds stall and discarded-fetch performance counters.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic [DATA_W-1:0] inst_rdata,
    output logic              inst_data_ok,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic [DATA_W-1:0] data_rdata,
    output logic              data_data_ok,
    input  logic              flush,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [1:0]        bus_size,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              stallreq_from_if,
    output logic              stallreq_from_mem
`ifdef MEM_BUS_ARBITER_PERF_EN
    ,
    output logic [31:0]       perf_if_stall,
    output logic [31:0]       perf_mem_stall,
    output logic [31:0]       perf_discard
`endif
);

    arb_state_e        state_q, state_d;
    arb_grant_e        grant_q, grant_d;
    logic              discard_q, discard_d;
    logic              wr_q, wr_d;
    logic [1:0]        size_q, size_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              xfer_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            grant_q   <= GrantInst;
            discard_q <= 1'b0;
            wr_q      <= 1'b0;
            size_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            discard_q <= discard_d;
            wr_q      <= wr_d;
            size_q    <= size_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        discard_d = discard_q;
        wr_d      = wr_q;
        size_d    = size_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        case (state_q)
            StIdle: begin
                if (data_req) begin
                    grant_d = GrantData;
                    wr_d    = data_wr;
                    size_d  = data_size;
                    addr_d  = data_addr;
                    wdata_d = data_wdata;
                    state_d = StAddr;
                end else if (inst_req) begin
                    grant_d = GrantInst;
                    wr_d    = 1'b0;
                    size_d  = SZ_WORD;
                    addr_d  = inst_addr;
                    wdata_d = '0;
                    state_d = StAddr;
                end
            end
            StAddr: begin
                if (flush && grant_q == GrantInst) discard_d = 1'b1;
                if (bus_addr_ok) state_d = StData;
            end
            StData: begin
                if (flush && grant_q == GrantInst) discard_d = 1'b1;
                if (bus_data_ok) begin
                    state_d   = StIdle;
                    discard_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign xfer_done = (state_q == StData) && bus_data_ok;

    // A flush landing on the completion cycle still kills the fetch response.
    assign inst_data_ok = xfer_done && (grant_q == GrantInst) && !discard_q && !flush;
    assign data_data_ok = xfer_done && (grant_q == GrantData);
    assign inst_rdata   = inst_data_ok ? bus_rdata : '0;
    assign data_rdata   = data_data_ok ? bus_rdata : '0;

    assign bus_req   = (state_q == StAddr);
    assign bus_wr    = wr_q;
    assign bus_size  = size_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;

    assign stallreq_from_if  = inst_req & ~inst_data_ok;
    assign stallreq_from_mem = data_req & ~data_data_ok;

`ifdef MEM_BUS_ARBITER_PERF_EN
    logic fetch_dropped;
    assign fetch_dropped = xfer_done && (grant_q == GrantInst) && (discard_q || flush);

    mem_arb_perf u_perf (
        .clk              (clk),
        .rst              (rst),
        .stall_if_i       (stallreq_from_if),
        .stall_mem_i      (stallreq_from_mem),
        .discard_i        (fetch_dropped),
        .perf_if_stall_o  (perf_if_stall),
        .perf_mem_stall_o (perf_mem_stall),
        .perf_discard_o   (perf_discard)
    );
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter with hand-computed expectations.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_data_ok;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_data_ok;
    logic        flush;
    logic        bus_req;
    logic        bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;
    logic        stallreq_from_if;
    logic        stallreq_from_mem;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter dut (
        .clk               (clk),
        .rst               (rst),
        .inst_req          (inst_req),
        .inst_addr         (inst_addr),
        .inst_rdata        (inst_rdata),
        .inst_data_ok      (inst_data_ok),
        .data_req          (data_req),
        .data_wr           (data_wr),
        .data_size         (data_size),
        .data_addr         (data_addr),
        .data_wdata        (data_wdata),
        .data_rdata        (data_rdata),
        .data_data_ok      (data_data_ok),
        .flush             (flush),
        .bus_req           (bus_req),
        .bus_wr            (bus_wr),
        .bus_size          (bus_size),
        .bus_addr          (bus_addr),
        .bus_wdata         (bus_wdata),
        .bus_addr_ok       (bus_addr_ok),
        .bus_data_ok       (bus_data_ok),
        .bus_rdata         (bus_rdata),
        .stallreq_from_if  (stallreq_from_if),
        .stallreq_from_mem (stallreq_from_mem)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance past the active edge; inputs change here, outputs are checked after settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1; inst_req = 1'b0; inst_addr = '0; data_req = 1'b0; data_wr = 1'b0;
        data_size = 2'd0; data_addr = '0; data_wdata = '0; flush = 1'b0;
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;
        tick(); tick();
        rst = 1'b0;
        settle();
        check_eq("rst_bus_req", {31'b0, bus_req}, 32'd0);
        check_eq("rst_bus_addr", bus_addr, 32'd0);
        check_eq("rst_inst_ok", {31'b0, inst_data_ok}, 32'd0);
        check_eq("rst_data_ok", {31'b0, data_data_ok}, 32'd0);

        // Fetch only
        inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
        settle();
        check_eq("f_idle_no_req", {31'b0, bus_req}, 32'd0);
        check_eq("f_stall_if", {31'b0, stallreq_from_if}, 32'd1);
        tick();
        check_eq("f_bus_req", {31'b0, bus_req}, 32'd1);
        check_eq("f_bus_addr", bus_addr, 32'hBFC0_0000);
        check_eq("f_bus_wr", {31'b0, bus_wr}, 32'd0);
        check_eq("f_bus_size", {30'b0, bus_size}, 32'd2);
        bus_addr_ok = 1'b1;
        tick();
        bus_addr_ok = 1'b0;
        settle();
        check_eq("f_data_no_req", {31'b0, bus_req}, 32'd0);
        check_eq("f_no_early_ok", {31'b0, inst_data_ok}, 32'd0);
        check_eq("f_stall_wait", {31'b0, stallreq_from_if}, 32'd1);
        tick();
        bus_data_ok = 1'b1; bus_rdata = 32'h3C08_0001;
        settle();
        check_eq("f_inst_ok", {31'b0, inst_data_ok}, 32'd1);
        check_eq("f_inst_rdata", inst_rdata, 32'h3C08_0001);
        check_eq("f_stall_drop", {31'b0, stallreq_from_if}, 32'd0);
        check_eq("f_no_data_ok", {31'b0, data_data_ok}, 32'd0);
        tick();
        bus_data_ok = 1'b0; inst_req = 1'b0;
        settle();
        check_eq("f_single_pulse", {31'b0, inst_data_ok}, 32'd0);

        // Simultaneous requests: MEM first, fetch follows
        inst_req = 1'b1; inst_addr = 32'h0000_1000;
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h0000_2000;
        tick();
        check_eq("s_bus_addr_mem", bus_addr, 32'h0000_2000);
        check_eq("s_stall_if", {31'b0, stallreq_from_if}, 32'd1);
        check_eq("s_stall_mem", {31'b0, stallreq_from_mem}, 32'd1);
        bus_addr_ok = 1'b1;
        tick();
        bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h0000_55AA;
        settle();
        check_eq("s_data_ok", {31'b0, data_data_ok}, 32'd1);
        check_eq("s_data_rdata", data_rdata, 32'h0000_55AA);
        check_eq("s_inst_not_ok", {31'b0, inst_data_ok}, 32'd0);
        check_eq("s_stall_if_held", {31'b0, stallreq_from_if}, 32'd1);
        tick();
        data_req = 1'b0; bus_data_ok = 1'b0;
        settle();
        check_eq("s_idle_no_req", {31'b0, bus_req}, 32'd0);
        tick();
        check_eq("s_fetch_addr", bus_addr, 32'h0000_1000);
        check_eq("s_fetch_req", {31'b0, bus_req}, 32'd1);
        bus_addr_ok = 1'b1;
        tick();
        bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h0000_0077;
        settle();
        check_eq("s_inst_ok", {31'b0, inst_data_ok}, 32'd1);
        check_eq("s_inst_rdata", inst_rdata, 32'h0000_0077);
        tick();
        inst_req = 1'b0; bus_data_ok = 1'b0;

        // Store with bus_addr_ok held low for 5 cycles
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd0;
        data_addr = 32'h8000_0003; data_wdata = 32'h0000_00AB;
        tick();
        for (int i = 0; i < 5; i++) begin
            check_eq("st_bus_req", {31'b0, bus_req}, 32'd1);
            check_eq("st_bus_wr", {31'b0, bus_wr}, 32'd1);
            check_eq("st_bus_size", {30'b0, bus_size}, 32'd0);
            check_eq("st_bus_addr", bus_addr, 32'h8000_0003);
            check_eq("st_bus_wdata", bus_wdata, 32'h0000_00AB);
            tick();
        end
        bus_addr_ok = 1'b1;
        tick();
        bus_addr_ok = 1'b0; bus_data_ok = 1'b1;
        settle();
        check_eq("st_data_ok", {31'b0, data_data_ok}, 32'd1);
        tick();
        data_req = 1'b0; data_wr = 1'b0; bus_data_ok = 1'b0;

        // Flush during fetch DATA phase
        inst_req = 1'b1; inst_addr = 32'h0000_0100;
        tick();
        bus_addr_ok = 1'b1;
        tick();
        bus_addr_ok = 1'b0; flush = 1'b1;
        settle();
        check_eq("fl_no_ok_flush", {31'b0, inst_data_ok}, 32'd0);
        tick();
        flush = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'hDEAD_0001;
        settle();
        check_eq("fl_discarded", {31'b0, inst_data_ok}, 32'd0);
        check_eq("fl_stall_if", {31'b0, stallreq_from_if}, 32'd1);
        tick();
        // Back in IDLE: new fetch, with a flush that must have no effect here
        bus_data_ok = 1'b0; inst_addr = 32'hBFC0_0380; flush = 1'b1;
        tick();
        flush = 1'b0;
        settle();
        check_eq("fl_new_addr", bus_addr, 32'hBFC0_0380);
        bus_addr_ok = 1'b1;
        tick();
        bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h0000_1234;
        settle();
        check_eq("fl_new_ok", {31'b0, inst_data_ok}, 32'd1);
        check_eq("fl_new_rdata", inst_rdata, 32'h0000_1234);
        tick();
        bus_data_ok = 1'b0; inst_addr = 32'h0000_0300;
        // Flush coinciding with bus_data_ok
        tick();
        bus_addr_ok = 1'b1;
        tick();
        bus_addr_ok = 1'b0; bus_data_ok = 1'b1; flush = 1'b1;
        settle();
        check_eq("fl_same_cycle", {31'b0, inst_data_ok}, 32'd0);
        tick();
        bus_data_ok = 1'b0; flush = 1'b0; inst_req = 1'b0;

        // Flush during store ADDR phase
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2;
        data_addr = 32'h0000_0040; data_wdata = 32'hDEAD_BEEF;
        tick();
        flush = 1'b1; bus_addr_ok = 1'b1;
        tick();
        flush = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b1;
        settle();
        check_eq("fs_store_ok", {31'b0, data_data_ok}, 32'd1);
        tick();
        data_req = 1'b0; data_wr = 1'b0; bus_data_ok = 1'b0;

        // Reset while in DATA
        inst_req = 1'b1; inst_addr = 32'h0000_0200;
        tick();
        bus_addr_ok = 1'b1;
        tick();
        bus_addr_ok = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0; inst_req = 1'b0; bus_data_ok = 1'b1;
        settle();
        check_eq("r_late_inst_ok", {31'b0, inst_data_ok}, 32'd0);
        check_eq("r_late_data_ok", {31'b0, data_data_ok}, 32'd0);
        check_eq("r_bus_req", {31'b0, bus_req}, 32'd0);
        check_eq("r_bus_addr", bus_addr, 32'd0);
        tick();
        bus_data_ok = 1'b0;
        settle();
        check_eq("r_stays_idle", {31'b0, bus_req}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one SRAM-like memory bus between the fetch port (IF) and the load/store port (MEM) of the 5-stage pipeline.
- Allows one outstanding transaction at a time. When both ports request, MEM wins.
- Produces stallreq_from_if and stallreq_from_mem for the hazard unit.
- Sits between the pipeline and the bus-to-AXI bridge.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- inst_req  in  1  fetch request; level, held until inst_data_ok.
- inst_addr  in  ADDR_W  fetch address.
- inst_rdata  out  DATA_W  fetch data; valid with inst_data_ok.
- inst_data_ok  out  1  one-cycle fetch completion pulse.
- data_req  in  1  load/store request; level, held until data_data_ok.
- data_wr  in  1  1 = store.
- data_size  in  2  0 = byte, 1 = half, 2 = word.
- data_addr  in  ADDR_W  load/store address.
- data_wdata  in  DATA_W  store data.
- data_rdata  out  DATA_W  load data; valid with data_data_ok.
- data_data_ok  out  1  one-cycle load/store completion pulse.
- flush  in  1  exception/ERET redirect from the hazard unit (flushALL).
- bus_req  out  1  bus request.
- bus_wr  out  1  bus write.
- bus_size  out  2  bus size.
- bus_addr  out  ADDR_W  bus address.
- bus_wdata  out  DATA_W  bus write data.
- bus_addr_ok  in  1  address accepted.
- bus_data_ok  in  1  data returned/written.
- bus_rdata  in  DATA_W  bus read data.
- stallreq_from_if  out  1  fetch stall request.
- stallreq_from_mem  out  1  memory-stage stall request.

Behaviour:
- FSM states: IDLE, ADDR, DATA. Registers: grant (INST/DATA), discard, and a latched request (wr, size, addr, wdata).
- Reset: state = IDLE, grant = INST, discard = 0, latched request = 0. All outputs are 0 after reset.
- IDLE:
  - data_req = 1 → latch the data fields, grant = DATA, go to ADDR.
  - else inst_req = 1 → latch inst_addr with wr = 0, size = 2, grant = INST, go to ADDR.
  - else stay in IDLE.
  - The grant decision is made in IDLE only. The bus is never requested from IDLE, so minimum latency is request → bus_req one cycle later.
- ADDR:
  - bus_req = 1; bus_* fields are driven from the latched request.
  - Stay until bus_addr_ok = 1, then go to DATA.
- DATA:
  - bus_req = 0.
  - On bus_data_ok, return to IDLE and clear discard.
  - Same cycle, pulse the granted port's data_ok; *_rdata = bus_rdata (combinational).
  - inst_data_ok is suppressed when discard = 1.
- Ports are not re-arbitrated the cycle after their own data_ok: IDLE is only re-entered then, so a request seen in IDLE is always a new request. Minimum per-access occupancy is 3 cycles.
- Flush:
  - flush = 1 with grant = INST in ADDR or DATA → discard = 1. The bus transaction still completes; no inst_data_ok is issued.
  - flush = 1 in IDLE → no effect.
  - flush never cancels a DATA-granted transaction, so stores always complete.
  - flush and bus_data_ok in the same cycle (INST grant) → the pulse is suppressed.
- Stalls (combinational):
  - stallreq_from_if = inst_req & ~inst_data_ok.
  - stallreq_from_mem = data_req & ~data_data_ok.
- Starvation: MEM strict priority is accepted; the pipeline cannot issue back-to-back data requests without fetches.
- rst = 1 mid-transaction abandons it: state returns to IDLE and discard clears. The bus bridge is reset on the same rst.
- bus_addr_ok or bus_data_ok arriving in an unexpected state is ignored.

Optional Feature:
- Macro: MEM_BUS_ARBITER_PERF_EN.
- Defined:
  - Adds outputs perf_if_stall[31:0] and perf_mem_stall[31:0].
  - Each counts cycles with its stallreq high, wraps at 2^32, and resets to 0 on rst.
  - Also adds perf_discard[31:0], which counts discarded fetches.
- Undefined: these ports and counters do not exist. Functional behaviour is identical.

Decomposition:
- Package mem_arb_pkg holds:
  - state encoding IDLE = 0, ADDR = 1, DATA = 2;
  - grant encoding INST = 0, DATA = 1;
  - size constants SZ_BYTE/SZ_HALF/SZ_WORD.
- FSM and datapath stay in one module.
- Under MEM_BUS_ARBITER_PERF_EN, the counters form sub-module mem_arb_perf.

Test Plan:
- Fetch only: inst_req = 1, addr 0xBFC00000, bus_addr_ok 1 cycle later, bus_data_ok 2 cycles later with 0x3C080001 → inst_data_ok pulses once with inst_rdata = 0x3C080001; stallreq_from_if is high until that cycle.
- Simultaneous requests: inst_req = data_req = 1 in IDLE → first bus_addr = data_addr; data_data_ok comes first; the fetch is issued in the following IDLE. Both stall requests stay high during the data access.
- Store: data_wr = 1, size = 0, addr 0x80000003, wdata 0xAB → bus_wr = 1, bus_size = 0, fields stable while bus_addr_ok is held low for 5 cycles.
- Flush during fetch: flush pulses in DATA with grant = INST → no inst_data_ok on bus_data_ok. The next inst_req (0xBFC00380) is serviced normally.
- Flush during store: flush in ADDR with grant = DATA → the store completes and data_data_ok pulses.
- Reset in DATA state: rst for 1 cycle → outputs 0, state IDLE; a late bus_data_ok produces no *_data_ok.
